// File: rtl/gpio_ctrl_multiport.sv
// Multi-port GPIO block: per-pin direction, output set/clear, synchronised inputs
// and edge-detected, write-1-to-clear interrupt flags behind a simple register bus.
`timescale 1ns/1ps
module gpio_ctrl_multiport #(
  parameter int PORT_W    = 16,
  parameter int NUM_PORTS = 4,
  parameter int PSEL_W    = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [PSEL_W-1:0]           i_port_sel,
  input  logic [2:0]                  i_reg_sel,
  input  logic                        i_we,
  input  logic                        i_re,
  input  logic [PORT_W-1:0]           i_wdata,
  output logic [PORT_W-1:0]           o_rdata,
  output logic                        o_rvalid,
  inout  wire  [NUM_PORTS*PORT_W-1:0] io_pins,
  output logic                        o_irq
);

  typedef enum logic [2:0] {
    REG_DIR      = 3'd0,
    REG_OUT      = 3'd1,
    REG_IN       = 3'd2,
    REG_IRQ_EN   = 3'd3,
    REG_IRQ_FLAG = 3'd4,
    REG_EDGE_POL = 3'd5,
    REG_OUT_SET  = 3'd6,
    REG_OUT_CLR  = 3'd7
  } reg_e;

  reg_e reg_sel;
  assign reg_sel = reg_e'(i_reg_sel);

  logic [PORT_W-1:0] dir_q   [NUM_PORTS];
  logic [PORT_W-1:0] out_q   [NUM_PORTS];
  logic [PORT_W-1:0] en_q    [NUM_PORTS];
  logic [PORT_W-1:0] flag_q  [NUM_PORTS];
  logic [PORT_W-1:0] pol_q   [NUM_PORTS];
  logic [PORT_W-1:0] sync1_q [NUM_PORTS];
  logic [PORT_W-1:0] in_q    [NUM_PORTS];
  logic [PORT_W-1:0] prev_q  [NUM_PORTS];
  logic [PORT_W-1:0] ev      [NUM_PORTS];
  logic [PORT_W-1:0] w1c     [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_hit;
  logic [PORT_W-1:0] rd_mux;
  logic [1:0] fill_q;

  for (genvar gi = 0; gi < NUM_PORTS*PORT_W; gi++) begin : g_pad
    assign io_pins[gi] = dir_q[gi / PORT_W][gi % PORT_W] ? out_q[gi / PORT_W][gi % PORT_W] : 1'bz;
  end

  // An edge is a change of IN whose new value matches the selected polarity
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      port_hit[p] = (i_port_sel == PSEL_W'(p));
      ev[p]  = (pol_q[p] & in_q[p] & ~prev_q[p]) | (~pol_q[p] & ~in_q[p] & prev_q[p]);
      w1c[p] = (i_we && port_hit[p] && reg_sel == REG_IRQ_FLAG) ? i_wdata : '0;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (port_hit[p]) begin
        case (reg_sel)
          REG_DIR:      rd_mux = dir_q[p];
          REG_OUT:      rd_mux = out_q[p];
          REG_IN:       rd_mux = in_q[p];
          REG_IRQ_EN:   rd_mux = en_q[p];
          REG_IRQ_FLAG: rd_mux = flag_q[p];
          REG_EDGE_POL: rd_mux = pol_q[p];
          default:      rd_mux = '0;
        endcase
      end
    end
  end

  always_comb begin
    o_irq = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      o_irq = o_irq | (|(flag_q[p] & en_q[p]));
    end
  end

  // Until the synchroniser has filled, prev loads the same value as IN, so
  // stale reset zeros never look like an edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fill_q <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        dir_q[p]   <= '0;
        out_q[p]   <= '0;
        en_q[p]    <= '0;
        flag_q[p]  <= '0;
        pol_q[p]   <= '0;
        sync1_q[p] <= '0;
        in_q[p]    <= '0;
        prev_q[p]  <= '0;
      end
    end else begin
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        sync1_q[p] <= io_pins[p*PORT_W +: PORT_W];
        in_q[p]    <= sync1_q[p];
        prev_q[p]  <= (fill_q == 2'd2) ? in_q[p] : sync1_q[p];
        flag_q[p]  <= (flag_q[p] & ~w1c[p]) | ev[p];
        if (i_we && port_hit[p]) begin
          case (reg_sel)
            REG_DIR:      dir_q[p] <= i_wdata;
            REG_OUT:      out_q[p] <= i_wdata;
            REG_IRQ_EN:   en_q[p]  <= i_wdata;
            REG_EDGE_POL: pol_q[p] <= i_wdata;
            REG_OUT_SET:  out_q[p] <= out_q[p] | i_wdata;
            REG_OUT_CLR:  out_q[p] <= out_q[p] & ~i_wdata;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= i_re;
      if (i_re) o_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_ctrl_multiport.sv
// Bench for gpio_ctrl_multiport: directed vector table plus randomized traffic
// checked against a pin-history reference model.
`timescale 1ns/1ps
module tb_gpio_ctrl_multiport;
  localparam int PW = 16;
  localparam int NP = 3;
  localparam int SW = 2;
  localparam int NB = NP*PW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, we, re, rvalid, irq;
  logic [SW-1:0] psel;
  logic [2:0]    rsel;
  logic [PW-1:0] wdata, rdata;
  wire  [NB-1:0] pins;
  logic [NB-1:0] drv, tb_en, m_dir_flat;

  // Reference model state
  logic [PW-1:0] m_dir [NP];
  logic [PW-1:0] m_out [NP];
  logic [PW-1:0] m_en  [NP];
  logic [PW-1:0] m_flag[NP];
  logic [PW-1:0] m_pol [NP];
  logic [NB-1:0] hist[$];
  int            cyc;
  logic          exp_rvalid, exp_irq;
  logic [PW-1:0] exp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar p = 0; p < NP; p++) begin : g_flat
    assign m_dir_flat[p*PW +: PW] = m_dir[p];
  end
  for (genvar i = 0; i < NB; i++) begin : g_drv
    assign pins[i] = (tb_en[i] && !m_dir_flat[i]) ? drv[i] : 1'bz;
  end

  gpio_ctrl_multiport #(.PORT_W(PW), .NUM_PORTS(NP), .PSEL_W(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_port_sel(psel), .i_reg_sel(rsel),
    .i_we(we), .i_re(re), .i_wdata(wdata), .o_rdata(rdata),
    .o_rvalid(rvalid), .io_pins(pins), .o_irq(irq)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: IN shows the pin sampled two edges earlier; an event
  // fires when consecutive IN samples differ and the new value equals EDGE_POL.
  task automatic model_edge();
    logic [NB-1:0] pin, nw, od;
    logic [PW-1:0] ev [NP];
    logic [PW-1:0] clr;
    int p;
    for (int i = 0; i < NB; i++)
      pin[i] = m_dir[i/PW][i%PW] ? m_out[i/PW][i%PW] : (tb_en[i] & drv[i]);
    if (!rst_n) begin
      for (int q = 0; q < NP; q++) begin
        m_dir[q] = '0; m_out[q] = '0; m_en[q] = '0; m_flag[q] = '0; m_pol[q] = '0;
      end
      hist.delete();
      hist.push_back('0);
      cyc = 1;
      exp_rvalid = 1'b0;
      exp_rdata  = '0;
      exp_irq    = 1'b0;
      return;
    end
    p = int'(psel);
    nw = (cyc >= 2) ? hist[hist.size()-2] : '0;
    od = (cyc >= 4) ? hist[hist.size()-3] : nw;
    if (re) begin
      exp_rdata = '0;
      if (p < NP) begin
        case (rsel)
          3'd0: exp_rdata = m_dir[p];
          3'd1: exp_rdata = m_out[p];
          3'd2: exp_rdata = nw[p*PW +: PW];
          3'd3: exp_rdata = m_en[p];
          3'd4: exp_rdata = m_flag[p];
          3'd5: exp_rdata = m_pol[p];
          default: exp_rdata = '0;
        endcase
      end
    end
    exp_rvalid = re;
    for (int q = 0; q < NP; q++)
      ev[q] = (nw[q*PW +: PW] ^ od[q*PW +: PW]) & ~(nw[q*PW +: PW] ^ m_pol[q]);
    clr = '0;
    if (we && p < NP) begin
      case (rsel)
        3'd0: m_dir[p] = wdata;
        3'd1: m_out[p] = wdata;
        3'd3: m_en[p]  = wdata;
        3'd4: clr      = wdata;
        3'd5: m_pol[p] = wdata;
        3'd6: m_out[p] = m_out[p] | wdata;
        3'd7: m_out[p] = m_out[p] & ~wdata;
        default: ;
      endcase
    end
    exp_irq = 1'b0;
    for (int q = 0; q < NP; q++) begin
      m_flag[q] = (m_flag[q] & ~((q == p) ? clr : '0)) | ev[q];
      exp_irq = exp_irq | (|(m_flag[q] & m_en[q]));
    end
    hist.push_back(pin);
    while (hist.size() > 3) void'(hist.pop_front());
    cyc++;
  endtask

  task automatic tick();
    int bad;
    @(posedge clk);
    #1;
    model_edge();
    #1;
    check("rvalid", rvalid, exp_rvalid);
    check("rdata", rdata, exp_rdata);
    check("irq", irq, exp_irq);
    bad = 0;
    for (int i = 0; i < NB; i++) begin
      if (m_dir_flat[i]) begin
        if (pins[i] !== m_out[i/PW][i%PW]) bad++;
      end else if (!tb_en[i] && pins[i] === 1'b1) begin
        bad++;
      end
    end
    check("pins_bad_bits", 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic        rst_n;
    logic [1:0]  psel;
    logic [2:0]  rsel;
    logic        we, re;
    logic [15:0] wdata, drv2;
    logic        xv;
    logic [15:0] xd;
    logic        xi;
  } vec_t;

  function automatic vec_t mk(logic r, int ps, int rs, logic w, logic rd, logic [15:0] wd,
                              logic [15:0] dv, logic xv, logic [15:0] xd, logic xi);
    vec_t v;
    v.rst_n = r; v.psel = 2'(ps); v.rsel = 3'(rs); v.we = w; v.re = rd;
    v.wdata = wd; v.drv2 = dv; v.xv = xv; v.xd = xd; v.xi = xi;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0; psel = '0; rsel = '0; wdata = '0;
    drv = '0; tb_en = {16'hFFFF, 32'h0};
    cyc = 0;
    for (int q = 0; q < NP; q++) begin
      m_dir[q] = '0; m_out[q] = '0; m_en[q] = '0; m_flag[q] = '0; m_pol[q] = '0;
    end

    //            rst ps rs we re wdata     drv2     xv xd        xi
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 16'h00FF, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 16'h1234, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 16'h0000, 16'h0000, 1, 16'h1234, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 16'hABCD, 16'h0000, 1, 16'h1234, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 16'h0000, 16'h0000, 1, 16'hABCD, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 16'h00F0, 16'h0000, 0, 16'hABCD, 0));
    tbl.push_back(mk(1, 0, 6, 1, 0, 16'h000F, 16'h0000, 0, 16'hABCD, 0));
    tbl.push_back(mk(1, 0, 7, 1, 0, 16'h0080, 16'h0000, 0, 16'hABCD, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 16'h0000, 16'h0000, 1, 16'h007F, 0));
    tbl.push_back(mk(1, 0, 6, 0, 1, 16'h0000, 16'h0000, 1, 16'h0000, 0));
    tbl.push_back(mk(1, 3, 0, 1, 0, 16'hFFFF, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 3, 0, 0, 1, 16'h0000, 16'h0000, 1, 16'h0000, 0));
    tbl.push_back(mk(1, 2, 5, 1, 0, 16'h0001, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 2, 3, 1, 0, 16'h0001, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 16'h0000, 1));
    tbl.push_back(mk(1, 2, 4, 0, 1, 16'h0000, 16'h0001, 1, 16'h0001, 1));
    tbl.push_back(mk(1, 2, 4, 1, 0, 16'h0001, 16'h0001, 0, 16'h0001, 0));
    tbl.push_back(mk(1, 2, 2, 1, 0, 16'hFFFF, 16'h0001, 0, 16'h0001, 0));
    tbl.push_back(mk(1, 2, 2, 0, 1, 16'h0000, 16'h0001, 1, 16'h0001, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0001, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0001, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0001, 0));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; psel = tbl[i].psel; rsel = tbl[i].rsel;
      we = tbl[i].we; re = tbl[i].re; wdata = tbl[i].wdata;
      drv = {tbl[i].drv2, 32'h0};
      tick();
      check("tbl_rvalid", rvalid, tbl[i].xv);
      check("tbl_rdata", rdata, tbl[i].xd);
      check("tbl_irq", irq, tbl[i].xi);
    end

    // Rising edge sets the flag, a falling edge does not (pol=1)
    we = 1'b0; re = 1'b0;
    drv[47:32] = 16'h0001;
    repeat (2) begin tick(); check("seq_irq_pending", irq, 1'b0); end
    tick(); check("seq_irq_set", irq, 1'b1);
    drv[47:32] = 16'h0000;
    repeat (3) begin tick(); check("seq_fall_ignored", irq, 1'b1); end
    // W1C on the same edge the flag is re-set: the new event wins
    drv[47:32] = 16'h0001;
    repeat (2) tick();
    psel = 2'd2; rsel = 3'd4; we = 1'b1; wdata = 16'h0001;
    tick(); check("seq_w1c_vs_event", irq, 1'b1);
    we = 1'b0; re = 1'b1;
    tick(); check("seq_flag_kept", rdata, 16'h0001);
    re = 1'b0; we = 1'b1;
    tick(); check("seq_w1c_clears", irq, 1'b0);
    // Reset mid-operation with outputs driven, flag set and a read pending
    psel = 2'd0; rsel = 3'd0; wdata = 16'hFFFF;
    tick();
    psel = 2'd2; rsel = 3'd5; wdata = 16'h0000;
    tick();
    we = 1'b0; drv[47:32] = 16'h0000;
    repeat (3) tick();
    check("seq_irq_before_rst", irq, 1'b1);
    re = 1'b1; rsel = 3'd4;
    tick();
    rst_n = 1'b0;
    tick();
    check("seq_rst_rvalid", rvalid, 1'b0);
    check("seq_rst_irq", irq, 1'b0);
    check("seq_rst_rdata", rdata, 16'h0000);
    re = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic against the model, all undriven pins fed by the bench
    tb_en = '1;
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      psel  = SW'($urandom_range(0, 3));
      rsel  = 3'($urandom_range(0, 7));
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 1));
      wdata = PW'($urandom);
      if ($urandom_range(0, 3) == 0) drv = NB'({$urandom, $urandom});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl_multiport.md
GPIO_CTRL_MULTIPORT -- requirements
Module: gpio_ctrl_multiport

Interface
REQ-001 Parameter PORT_W, default 16: bits per GPIO port.
REQ-002 Parameter NUM_PORTS, default 4: number of GPIO ports, 1..2**PSEL_W.
REQ-003 Parameter PSEL_W, default 2: width of port-select field.
REQ-004 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_port_sel  in  PSEL_W  port index for the current access.
REQ-007 i_reg_sel  in  3  register index for the current access (map in REQ-012).
REQ-008 i_we  in  1  write strobe, one-cycle, i_wdata sampled same edge.
REQ-009 i_re  in  1  read strobe, one-cycle.
REQ-010 i_wdata  in  PORT_W  write data; o_rdata  out  PORT_W  read data; o_rvalid  out  1  read-data-valid pulse.
REQ-011 io_pins  inout  NUM_PORTS*PORT_W  pad bits, port p at bits [p*PORT_W +: PORT_W]; o_irq  out  1  combined interrupt.

Function
REQ-012 Per-port registers SHALL be: 0 DIR (1=output), 1 OUT, 2 IN (RO), 3 IRQ_EN, 4 IRQ_FLAG (W1C), 5 EDGE_POL (1=rising, 0=falling), 6 OUT_SET (WO), 7 OUT_CLR (WO).
REQ-013 io_pins bit SHALL drive OUT bit when DIR bit=1, else high-Z.
REQ-014 Each pin SHALL pass a 2-flop synchroniser; IN = second stage; a third flop holds previous IN for edge detection.
REQ-015 Pin change stable before edge k SHALL be readable in IN after edge k+1.
REQ-016 Edge event per bit: EDGE_POL=1 and IN 0->1, or EDGE_POL=0 and IN 1->0; event SHALL set IRQ_FLAG bit at edge k+2 relative to REQ-015 pin change, regardless of DIR or IRQ_EN.
REQ-017 o_irq SHALL be combinational OR over all ports of (IRQ_FLAG & IRQ_EN).
REQ-018 Write to OUT_SET SHALL do OUT |= i_wdata; OUT_CLR SHALL do OUT &= ~i_wdata; single cycle, no read-modify-write by master.
REQ-019 Write to IRQ_FLAG SHALL clear bits where i_wdata=1; a new edge event on the same bit in the same cycle SHALL win (bit stays 1).
REQ-020 Writes to IN SHALL be ignored.
REQ-021 Read: o_rdata and o_rvalid SHALL be registered, valid exactly one cycle after i_re; o_rvalid high for one cycle; o_rdata holds until next read.
REQ-022 Reads of OUT_SET/OUT_CLR SHALL return 0.
REQ-023 i_port_sel >= NUM_PORTS: writes ignored, reads return 0 with o_rvalid asserted.
REQ-024 i_we and i_re in the same cycle to the same register: both performed; o_rdata returns the pre-write value.
REQ-025 Back-to-back reads every cycle SHALL be supported (throughput 1 read/cycle).

Reset
REQ-026 While i_rst_n=0 at a rising edge: DIR, OUT, IRQ_EN, IRQ_FLAG, EDGE_POL, synchroniser and previous-value flops = 0; o_rdata=0; o_rvalid=0.
REQ-027 After reset all pins SHALL be high-Z and o_irq=0; no edge event SHALL be generated on the first cycles after reset from synchroniser fill (previous-value flop loads along with IN, reset mid-operation discards pending read).

Verification
REQ-028 Reset, port 1: write DIR=0x00FF, OUT=0x1234 -> io_pins[31:16] = 16'bZZZZZZZZ_00110100; read OUT -> o_rdata=0x1234 one cycle after i_re.
REQ-029 Port 0 OUT=0x00F0; write OUT_SET=0x000F then OUT_CLR=0x0080 -> read OUT = 0x007F.
REQ-030 Port 2 DIR=0, EDGE_POL=0x0001, IRQ_EN=0x0001; drive pin 32 0->1 before edge k -> IRQ_FLAG[0]=1 after edge k+2, o_irq=1; write IRQ_FLAG=0x0001 -> o_irq=0.
REQ-031 Same setup, W1C write coincident with new rising edge event on bit 0 -> IRQ_FLAG[0] stays 1, o_irq stays 1.
REQ-032 i_port_sel=3 with NUM_PORTS=3: write 0xFFFF to DIR -> no pin driven; read -> o_rdata=0, o_rvalid=1.
REQ-033 Assert i_rst_n=0 with DIR=0xFFFF, IRQ_FLAG nonzero -> next edge: all pins Z, o_irq=0, o_rvalid=0.
